// File: rtl/uart_frame_ctrl.sv
// ---------------------------------------------------------------------------
// uart_frame_ctrl
//   Assembles the byte stream coming out of uart_rx into command frames of the
//   form SYNC, CMD, LEN, DATA[0..LEN-1], CHK, and checks each one. CHK is the
//   XOR of CMD, LEN and every DATA byte. A good frame is latched onto the
//   frame_* outputs and announced with a one-cycle frame_valid pulse. Bad
//   frames raise a one-cycle error pulse and leave frame_* unchanged.
//
//   Optional feature (compile-time macro UART_FRAME_TIMEOUT_EN):
//     when defined, an inter-byte watchdog aborts a partial frame after
//     TIMEOUT_CLKS idle cycles and pulses err_timeout. When not defined, no
//     watchdog is built, err_timeout is tied 0, and the FSM waits forever.
//
// Ports
//   clk          in   1   system clock
//   rst          in   1   synchronous reset, active-high
//   rx_valid     in   1   one-cycle strobe, rx_byte is valid
//   rx_byte      in   8   received byte
//   frame_valid  out  1   one-cycle pulse, good frame on frame_*
//   frame_cmd    out  8   CMD of the last good frame
//   frame_len    out  3   LEN of the last good frame
//   frame_data   out  32  payload, DATA[i] in bits [8i+7:8i], unused bytes 0
//   err_chk      out  1   one-cycle pulse, checksum mismatch
//   err_len      out  1   one-cycle pulse, LEN > MAX_LEN
//   err_timeout  out  1   one-cycle pulse, inter-byte timeout
//   busy         out  1   high while a frame is in progress
//   frame_count  out  8   number of good frames, wraps 255 -> 0
// ---------------------------------------------------------------------------
module uart_frame_ctrl #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          MAX_LEN      = 4,
  parameter logic [31:0] TIMEOUT_CLKS = 32'd100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        frame_valid,
  output logic [7:0]  frame_cmd,
  output logic [2:0]  frame_len,
  output logic [31:0] frame_data,
  output logic        err_chk,
  output logic        err_len,
  output logic        err_timeout,
  output logic        busy,
  output logic [7:0]  frame_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_CHK  = 3'd4
  } state_e;

  // LEN is compared on all 8 received bits, so e.g. 8'h0C is rejected even
  // though its low 3 bits would fit.
  localparam logic [7:0] MaxLenB = 8'(MAX_LEN);

  state_e state_q, state_d;

  // Working registers for the frame being received.
  logic [7:0]  cmd_q, cmd_d;
  logic [2:0]  len_q, len_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  chk_q, chk_d;

  // Registered outputs.
  logic        frame_valid_q, frame_valid_d;
  logic [7:0]  frame_cmd_q, frame_cmd_d;
  logic [2:0]  frame_len_q, frame_len_d;
  logic [31:0] frame_data_q, frame_data_d;
  logic        err_chk_q, err_chk_d;
  logic        err_len_q, err_len_d;
  logic        err_timeout_q, err_timeout_d;
  logic [7:0]  frame_count_q, frame_count_d;

  logic        tmo_hit;

`ifdef UART_FRAME_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;

  // The abort is decided in the cycle where the counter would step onto
  // TIMEOUT_CLKS-1, so the registered pulse lands TIMEOUT_CLKS-1 clocks after
  // the last accepted byte. A byte in that same cycle takes priority.
  always_comb begin
    tmo_hit   = (state_q != S_IDLE) && !rx_valid &&
                (tmo_cnt_q == (TIMEOUT_CLKS - 32'd2));
    tmo_cnt_d = tmo_cnt_q + 32'd1;
    if (rx_valid || (state_q == S_IDLE) || tmo_hit) begin
      tmo_cnt_d = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= 32'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  // No watchdog: the term is constant 0; TIMEOUT_CLKS stays referenced so
  // both builds take the same parameter list.
  assign tmo_hit = (TIMEOUT_CLKS == 32'd0) && 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (tmo_hit) begin
      state_d = S_IDLE;
    end else if (rx_valid) begin
      case (state_q)
        S_IDLE: if (rx_byte == SYNC_BYTE) state_d = S_CMD;
        S_CMD:  state_d = S_LEN;
        S_LEN: begin
          if (rx_byte > MaxLenB)      state_d = S_IDLE;
          else if (rx_byte == 8'd0)   state_d = S_CHK;
          else                        state_d = S_DATA;
        end
        S_DATA: if ((idx_q + 3'd1) == len_q) state_d = S_CHK;
        S_CHK:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output and working-register logic
  always_comb begin
    cmd_d         = cmd_q;
    len_d         = len_q;
    idx_d         = idx_q;
    data_d        = data_q;
    chk_d         = chk_q;
    frame_valid_d = 1'b0;
    frame_cmd_d   = frame_cmd_q;
    frame_len_d   = frame_len_q;
    frame_data_d  = frame_data_q;
    err_chk_d     = 1'b0;
    err_len_d     = 1'b0;
    err_timeout_d = tmo_hit;
    frame_count_d = frame_count_q;

    if (rx_valid) begin
      case (state_q)
        S_CMD: begin
          cmd_d = rx_byte;
          chk_d = rx_byte;
        end
        S_LEN: begin
          if (rx_byte > MaxLenB) begin
            err_len_d = 1'b1;
          end else begin
            // Zero-length frames also clear the payload so a good one
            // presents frame_data = 0.
            len_d  = rx_byte[2:0];
            idx_d  = 3'd0;
            data_d = 32'd0;
            chk_d  = chk_q ^ rx_byte;
          end
        end
        S_DATA: begin
          data_d[{idx_q[1:0], 3'b000} +: 8] = rx_byte;
          idx_d = idx_q + 3'd1;
          chk_d = chk_q ^ rx_byte;
        end
        S_CHK: begin
          if (rx_byte == chk_q) begin
            frame_valid_d = 1'b1;
            frame_cmd_d   = cmd_q;
            frame_len_d   = len_q;
            frame_data_d  = data_q;
            frame_count_d = frame_count_q + 8'd1;
          end else begin
            err_chk_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q         <= 8'd0;
      len_q         <= 3'd0;
      idx_q         <= 3'd0;
      data_q        <= 32'd0;
      chk_q         <= 8'd0;
      frame_valid_q <= 1'b0;
      frame_cmd_q   <= 8'd0;
      frame_len_q   <= 3'd0;
      frame_data_q  <= 32'd0;
      err_chk_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      cmd_q         <= cmd_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      data_q        <= data_d;
      chk_q         <= chk_d;
      frame_valid_q <= frame_valid_d;
      frame_cmd_q   <= frame_cmd_d;
      frame_len_q   <= frame_len_d;
      frame_data_q  <= frame_data_d;
      err_chk_q     <= err_chk_d;
      err_len_q     <= err_len_d;
      err_timeout_q <= err_timeout_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_cmd   = frame_cmd_q;
  assign frame_len   = frame_len_q;
  assign frame_data  = frame_data_q;
  assign err_chk     = err_chk_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_timeout_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_count = frame_count_q;

endmodule
